// File: rtl/uart_duplex.sv
`default_nettype none
// ============================================================================
// Module   : uart_duplex
// Purpose  : Parametrised full-duplex UART, independent RX/TX engines, one clock
// Revision : 1.0
// ============================================================================
module uart_duplex #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 12_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  input  logic                  read_ready,
  output logic                  read_parity_err,
  output logic                  read_frame_err,
  output logic                  read_overrun,
  output logic                  tx,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_valid,
  output logic                  write_ready
);

  localparam int CPB   = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = (CPB > 2) ? $clog2(CPB) : 2;

  localparam logic [CNT_W-1:0] c_cnt_full  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] c_cnt_half  = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [3:0]       c_last_data = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]       c_last_stop = 4'(STOP_BITS - 1);
  localparam logic             c_odd       = (PARITY == 1);

  if (CPB < 4) begin : g_chk_cpb
    $error("uart_duplex: CLK_FREQ/BAUD_RATE must be at least 4");
  end
  if (PARITY > 2 || PARITY < 0) begin : g_chk_parity
    $error("uart_duplex: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_duplex: STOP_BITS must be 1 or 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_chk_width
    $error("uart_duplex: DATA_WIDTH must be 5..9");
  end

  // ---------------------------------------------------------------- rx sync
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------- rx fsm
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  rx_state_e             rx_state_q, rx_state_d;
  logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic [3:0]            rx_bit_q, rx_bit_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic                  rx_perr_q, rx_perr_d;
  logic                  rx_done;
  logic                  rx_ferr;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = c_cnt_half;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_s_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = c_cnt_full;
            rx_bit_d   = '0;
            rx_perr_d  = 1'b0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - c_cnt_one;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_s_q, rx_shift_q[DATA_WIDTH-1:1]};
          rx_cnt_d   = c_cnt_full;
          if (rx_bit_q == c_last_data) begin
            rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - c_cnt_one;
        end
      end
      RX_PARITY: begin
        if (rx_cnt_q == '0) begin
          // odd parity wants the XOR of data and parity bit to be 1, even wants 0
          rx_perr_d  = ((^rx_shift_q) ^ rx_s_q) != c_odd;
          rx_cnt_d   = c_cnt_full;
          rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - c_cnt_one;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_done    = 1'b1;
          rx_ferr    = ~rx_s_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - c_cnt_one;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  // ---------------------------------------------------------------- rx output register
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_perr_q, rd_perr_d;
  logic                  rd_ferr_q, rd_ferr_d;
  logic                  rd_ovr_q, rd_ovr_d;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    rd_perr_d  = rd_perr_q;
    rd_ferr_d  = rd_ferr_q;
    rd_ovr_d   = rd_ovr_q;
    if (rd_valid_q && read_ready) begin
      rd_valid_d = 1'b0;
      rd_perr_d  = 1'b0;
      rd_ferr_d  = 1'b0;
      rd_ovr_d   = 1'b0;
    end
    if (rx_done) begin
      if (!rd_valid_q || read_ready) begin
        rd_data_d  = rx_shift_q;
        rd_valid_d = 1'b1;
        rd_perr_d  = rx_perr_q;
        rd_ferr_d  = rx_ferr;
        rd_ovr_d   = 1'b0;
      end else begin
        rd_ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_perr_q  <= 1'b0;
      rd_ferr_q  <= 1'b0;
      rd_ovr_q   <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_perr_q  <= rd_perr_d;
      rd_ferr_q  <= rd_ferr_d;
      rd_ovr_q   <= rd_ovr_d;
    end
  end

  assign read_data       = rd_data_q;
  assign read_valid      = rd_valid_q;
  assign read_parity_err = rd_perr_q;
  assign read_frame_err  = rd_ferr_q;
  assign read_overrun    = rd_ovr_q;

  // ---------------------------------------------------------------- tx fsm
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  tx_state_e             tx_state_q, tx_state_d;
  logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
  logic [3:0]            tx_bit_q, tx_bit_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_q, tx_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (write_valid) begin
          tx_shift_d = write_data;
          tx_par_d   = (^write_data) ^ c_odd;
          tx_d       = 1'b0;
          tx_cnt_d   = c_cnt_full;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_d       = tx_shift_q[0];
          tx_bit_d   = '0;
          tx_cnt_d   = c_cnt_full;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - c_cnt_one;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = c_cnt_full;
          if (tx_bit_q == c_last_data) begin
            tx_bit_d = '0;
            if (PARITY != 0) begin
              tx_d       = tx_par_q;
              tx_state_d = TX_PARITY;
            end else begin
              tx_d       = 1'b1;
              tx_state_d = TX_STOP;
            end
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
            tx_d       = tx_shift_q[1];
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - c_cnt_one;
        end
      end
      TX_PARITY: begin
        if (tx_cnt_q == '0) begin
          tx_d       = 1'b1;
          tx_bit_d   = '0;
          tx_cnt_d   = c_cnt_full;
          tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q - c_cnt_one;
        end
      end
      TX_STOP: begin
        tx_d = 1'b1;
        if (tx_cnt_q == '0) begin
          if (tx_bit_q == c_last_stop) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            tx_cnt_d = c_cnt_full;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - c_cnt_one;
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  assign tx          = tx_q;
  assign write_ready = (tx_state_q == TX_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_duplex.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_duplex
// Purpose  : Self-checking bench; unit 0 uses defaults, unit 1 even parity + 2 stops
// Revision : 1.0
// ============================================================================
module tb_uart_duplex;
  localparam int CPB = 104;
  localparam int DW  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       loop, rx_drv, rxw, txw, rv, rr, pe, fe, ov, wv, wr;
  logic [1:0][7:0]  rd, wd;

  assign rxw[0] = loop[0] ? txw[0] : rx_drv[0];
  assign rxw[1] = loop[1] ? txw[1] : rx_drv[1];

  uart_duplex u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rxw[0]),
    .read_data(rd[0]), .read_valid(rv[0]), .read_ready(rr[0]),
    .read_parity_err(pe[0]), .read_frame_err(fe[0]), .read_overrun(ov[0]),
    .tx(txw[0]), .write_data(wd[0]), .write_valid(wv[0]), .write_ready(wr[0])
  );

  uart_duplex #(.PARITY(2), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rxw[1]),
    .read_data(rd[1]), .read_valid(rv[1]), .read_ready(rr[1]),
    .read_parity_err(pe[1]), .read_frame_err(fe[1]), .read_overrun(ov[1]),
    .tx(txw[1]), .write_data(wd[1]), .write_valid(wv[1]), .write_ready(wr[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  // accepted words as {overrun, frame_err, parity_err, data}
  logic [10:0] got_a[$];
  logic [10:0] got_b[$];

  always @(posedge clk) begin
    if (rv[0] && rr[0]) got_a.push_back({ov[0], fe[0], pe[0], rd[0]});
    if (rv[1] && rr[1]) got_b.push_back({ov[1], fe[1], pe[1], rd[1]});
  end

  function automatic int frame_bits(input int u);
    return (u == 0) ? 10 : 12;
  endfunction

  function automatic logic exp_bit(input int u, input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= DW) return d[b-1];
    if (u == 1 && b == DW + 1) return ($countones(d) % 2) != 0;
    return 1'b1;
  endfunction

  function automatic logic exp_perr(input int u, input logic [7:0] d, input logic p);
    if (u == 0) return 1'b0;
    return (($countones(d) + int'(p)) % 2) != 0;
  endfunction

  function automatic int got_size(input int u);
    return (u == 0) ? got_a.size() : got_b.size();
  endfunction

  task automatic drive_bit(input int u, input logic v);
    rx_drv[u] = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_rx(input int u, input logic [7:0] d, input bit has_par,
                         input logic pbit, input logic stopv);
    @(negedge clk);
    drive_bit(u, 1'b0);
    for (int i = 0; i < DW; i++) drive_bit(u, d[i]);
    if (has_par) drive_bit(u, pbit);
    drive_bit(u, stopv);
    rx_drv[u] = 1'b1;
    if (!stopv) repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic wait_rx(input int u, input int n, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 4000 && !ok; t++) begin
      if (got_size(u) >= n) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  // sends one word and records how the line and write_ready behaved
  task automatic tx_send(input int u, input logic [7:0] d, output int bad_bits,
                         output int low_cycles, output bit started);
    int cyc;
    bad_bits   = 0;
    low_cycles = 0;
    started    = 1'b0;
    for (int t = 0; t < 3000 && !started; t++) begin
      @(negedge clk);
      if (wr[u] === 1'b1) started = 1'b1;
    end
    if (!started) return;
    wd[u] = d;
    wv[u] = 1'b1;
    @(negedge clk);
    wd[u] = ~d;
    cyc   = 0;
    for (int b = 0; b < frame_bits(u); b++) begin
      int wrong = 0;
      for (int c = 0; c < CPB; c++) begin
        if (txw[u] !== exp_bit(u, d, b)) wrong++;
        if (wr[u] === 1'b0) low_cycles++;
        cyc++;
        if (cyc == 50) wv[u] = 1'b0;
        @(negedge clk);
      end
      if (wrong != 0) bad_bits++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; loop = 2'b00; rx_drv = 2'b11; rr = 2'b11; wv = 2'b00; wd = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      n_cmp++; if (txw[u] !== 1'b1) begin n_bad++; $display("FAIL reset_tx u%0d: got %b want 1", u, txw[u]); end
      n_cmp++; if (wr[u] !== 1'b1) begin n_bad++; $display("FAIL reset_write_ready u%0d: got %b want 1", u, wr[u]); end
      n_cmp++; if (rv[u] !== 1'b0) begin n_bad++; $display("FAIL reset_read_valid u%0d: got %b want 0", u, rv[u]); end
      n_cmp++; if ({ov[u], fe[u], pe[u], rd[u]} !== 11'h0) begin
        n_bad++; $display("FAIL reset_read_regs u%0d: got %h want 000", u, {ov[u], fe[u], pe[u], rd[u]});
      end
    end
  endtask

  task automatic test_tx_frame();
    int bad, low; bit st;
    loop[0] = 1'b0;
    tx_send(0, 8'hA5, bad, low, st);
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL tx_a5_start: got %b want 1", st); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL tx_a5_bits: got %0d wrong bits want 0", bad); end
    n_cmp++; if (low != 1040) begin n_bad++; $display("FAIL tx_a5_busy: got %0d cycles want 1040", low); end
    n_cmp++; if (wr[0] !== 1'b1 || txw[0] !== 1'b1) begin
      n_bad++; $display("FAIL tx_a5_end: got ready=%b tx=%b want 1 1", wr[0], txw[0]);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] words[$];
    int bad, low; bit st, ok;
    loop[0] = 1'b1;
    got_a.delete();
    words.push_back(8'h3C);
    words.push_back(8'hC3);
    for (int i = 0; i < 4; i++) words.push_back(8'($urandom));
    foreach (words[i]) begin
      tx_send(0, words[i], bad, low, st);
      n_cmp++; if (!st || bad != 0 || low != 1040) begin
        n_bad++; $display("FAIL loop_tx%0d: got start=%b bad=%0d busy=%0d want 1 0 1040", i, st, bad, low);
      end
    end
    wait_rx(0, words.size(), ok);
    n_cmp++; if (got_a.size() != words.size()) begin
      n_bad++; $display("FAIL loop_count: got %0d want %0d", got_a.size(), words.size());
    end
    foreach (words[i]) begin
      if (i < got_a.size()) begin
        n_cmp++; if (got_a[i] !== {3'b000, words[i]}) begin
          n_bad++; $display("FAIL loop_word%0d: got %h want %h", i, got_a[i], {3'b000, words[i]});
        end
      end
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] d; bit ok;
    loop[0] = 1'b0;
    got_a.delete();
    d = 8'($urandom);
    send_rx(0, 8'h55, 1'b0, 1'b0, 1'b0);
    send_rx(0, d, 1'b0, 1'b0, 1'b1);
    wait_rx(0, 2, ok);
    n_cmp++; if (!ok || got_a.size() != 2) begin
      n_bad++; $display("FAIL ferr_count: got %0d want 2", got_a.size());
    end else begin
      n_cmp++; if (got_a[0] !== {3'b010, 8'h55}) begin
        n_bad++; $display("FAIL ferr_word: got %h want %h", got_a[0], {3'b010, 8'h55});
      end
      n_cmp++; if (got_a[1] !== {3'b000, d}) begin
        n_bad++; $display("FAIL ferr_clean: got %h want %h", got_a[1], {3'b000, d});
      end
    end
  endtask

  task automatic test_parity_rx();
    logic [10:0] exp[$];
    logic [7:0] d; logic p, s; bit ok;
    loop[1] = 1'b0;
    got_b.delete();
    send_rx(1, 8'h07, 1'b1, 1'b0, 1'b1);
    exp.push_back({2'b00, exp_perr(1, 8'h07, 1'b0), 8'h07});
    send_rx(1, 8'h07, 1'b1, 1'b1, 1'b1);
    exp.push_back({2'b00, exp_perr(1, 8'h07, 1'b1), 8'h07});
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      s = ($urandom_range(0, 3) != 0);
      send_rx(1, d, 1'b1, p, s);
      exp.push_back({1'b0, ~s, exp_perr(1, d, p), d});
    end
    wait_rx(1, exp.size(), ok);
    n_cmp++; if (got_b.size() != exp.size()) begin
      n_bad++; $display("FAIL par_count: got %0d want %0d", got_b.size(), exp.size());
    end
    foreach (exp[i]) begin
      if (i < got_b.size()) begin
        n_cmp++; if (got_b[i] !== exp[i]) begin
          n_bad++; $display("FAIL par_word%0d: got %h want %h", i, got_b[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_parity_tx();
    logic [7:0] d[2];
    int bad, low; bit st, ok;
    loop[1] = 1'b1;
    got_b.delete();
    for (int i = 0; i < 2; i++) begin
      d[i] = 8'($urandom);
      tx_send(1, d[i], bad, low, st);
      n_cmp++; if (!st || bad != 0 || low != 12 * CPB) begin
        n_bad++; $display("FAIL ptx_frame%0d: got start=%b bad=%0d busy=%0d want 1 0 %0d", i, st, bad, low, 12 * CPB);
      end
    end
    wait_rx(1, 2, ok);
    n_cmp++; if (got_b.size() != 2) begin
      n_bad++; $display("FAIL ptx_count: got %0d want 2", got_b.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_cmp++; if (got_b[i] !== {3'b000, d[i]}) begin
          n_bad++; $display("FAIL ptx_word%0d: got %h want %h", i, got_b[i], {3'b000, d[i]});
        end
      end
    end
    loop[1] = 1'b0;
  endtask

  task automatic test_overrun();
    loop[0] = 1'b0;
    rr[0] = 1'b0;
    got_a.delete();
    send_rx(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_rx(0, 8'h22, 1'b0, 1'b0, 1'b1);
    repeat (CPB) @(negedge clk);
    n_cmp++; if ({rv[0], ov[0], fe[0], pe[0], rd[0]} !== {4'b1100, 8'h11}) begin
      n_bad++; $display("FAIL ovr_held: got v=%b o=%b f=%b p=%b d=%h want 1 1 0 0 11", rv[0], ov[0], fe[0], pe[0], rd[0]);
    end
    rr[0] = 1'b1;
    @(negedge clk);
    n_cmp++; if (rv[0] !== 1'b0 || ov[0] !== 1'b0) begin
      n_bad++; $display("FAIL ovr_clear: got v=%b o=%b want 0 0", rv[0], ov[0]);
    end
    n_cmp++; if (got_a.size() != 1 || got_a[0] !== {3'b100, 8'h11}) begin
      n_bad++; $display("FAIL ovr_accept: got n=%0d w=%h want 1 %h", got_a.size(),
                        (got_a.size() > 0) ? got_a[0] : 11'h0, {3'b100, 8'h11});
    end
  endtask

  task automatic test_false_start();
    logic [7:0] d; bit ok;
    loop[0] = 1'b0;
    got_a.delete();
    @(negedge clk);
    rx_drv[0] = 1'b0;
    repeat (30) @(negedge clk);
    rx_drv[0] = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_cmp++; if (got_a.size() != 0 || rv[0] !== 1'b0) begin
      n_bad++; $display("FAIL glitch: got n=%0d valid=%b want 0 0", got_a.size(), rv[0]);
    end
    d = 8'($urandom);
    send_rx(0, d, 1'b0, 1'b0, 1'b1);
    wait_rx(0, 1, ok);
    n_cmp++; if (!ok || got_a[0] !== {3'b000, d}) begin
      n_bad++; $display("FAIL glitch_next: got n=%0d w=%h want %h", got_a.size(),
                        ok ? got_a[0] : 11'h0, {3'b000, d});
    end
  endtask

  task automatic test_reset_mid_tx();
    int bad, low; bit st, ok;
    loop[0] = 1'b1;
    for (int t = 0; t < 3000 && wr[0] !== 1'b1; t++) @(negedge clk);
    wd[0] = 8'hFF;
    wv[0] = 1'b1;
    @(negedge clk);
    wv[0] = 1'b0;
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (txw[0] !== 1'b1 || wr[0] !== 1'b1 || rv[0] !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid: got tx=%b ready=%b valid=%b want 1 1 0", txw[0], wr[0], rv[0]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    got_a.delete();
    tx_send(0, 8'h5A, bad, low, st);
    n_cmp++; if (!st || bad != 0 || low != 1040) begin
      n_bad++; $display("FAIL rst_next_tx: got start=%b bad=%0d busy=%0d want 1 0 1040", st, bad, low);
    end
    wait_rx(0, 1, ok);
    n_cmp++; if (got_a.size() != 1 || got_a[0] !== {3'b000, 8'h5A}) begin
      n_bad++; $display("FAIL rst_next_rx: got n=%0d w=%h want 1 %h", got_a.size(),
                        (got_a.size() > 0) ? got_a[0] : 11'h0, {3'b000, 8'h5A});
    end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_loopback();
    test_frame_err();
    test_parity_rx();
    test_parity_tx();
    test_overrun();
    test_false_start();
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
